fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that lets NUM_REQ producers share the write port of one sync_fifo instance. It grants one producer at a time, holds the grant for a bounded burst, and stalls on FIFO FULL. It drives the FIFO's W_EN and DATA_IN directly and back-pressures producers with per-requester valid/ready handshakes.

---
 rtl/fifo_wr_arbiter_pkg.sv | 10 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 67 ++++++
 tb/tb_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared state encoding and width helper for the FIFO write arbiter
package fifo_wr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: combinational round-robin selector starting just above last_id
module fifo_wr_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_id,
  output logic [IDX_W-1:0]   next_id,
  output logic               any
);
  int idx;
  // scan downward in priority so the nearest requester above last_id is written last and wins
  always_comb begin
    next_id = '0;
    any = 1'b0;
    idx = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_id) + i) % NUM_REQ;
      if (req[idx]) begin
        next_id = IDX_W'(idx);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX_W = clog2(NUM_REQ),
  parameter int MAX_BURST = 4,
  parameter int BURST_W = clog2(MAX_BURST) + 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_W_EN,
  output logic [DATA_WIDTH-1:0]         FIFO_DATA_IN,
  output logic [REQ_IDX_W-1:0]          GRANT_ID,
  output logic                          BUSY
);
  state_t               state;
  logic [REQ_IDX_W-1:0] last_id;
  logic [REQ_IDX_W-1:0] pick_id;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 pick_any;
  logic                 xfer;
  logic                 last_word;
  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W(REQ_IDX_W)
  ) u_pick (
    .req(REQ_VALID),
    .last_id(last_id),
    .next_id(pick_id),
    .any(pick_any)
  );
  // handshake and FIFO drive follow the grant holder; FULL is sampled combinationally so a freed slot is used at once
  always_comb begin
    BUSY = state == ST_GRANT;
    xfer = BUSY && REQ_VALID[GRANT_ID] && !FIFO_FULL;
    last_word = burst_cnt == BURST_W'(MAX_BURST - 1);
    FIFO_W_EN = xfer;
    REQ_READY = xfer ? NUM_REQ'(1) << GRANT_ID : '0;
    FIFO_DATA_IN = BUSY ? REQ_DATA[GRANT_ID*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  // grant FSM: one-cycle arbitration in IDLE, bounded burst in GRANT, release on drop or burst end, hold on FULL
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      GRANT_ID <= '0;
      last_id <= REQ_IDX_W'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_any) begin
        state <= ST_GRANT;
        GRANT_ID <= pick_id;
        burst_cnt <= '0;
      end
    end else if (!REQ_VALID[GRANT_ID] || (xfer && last_word)) begin
      state <= ST_IDLE;
      last_id <= GRANT_ID;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, corner sequences and randomized model checks for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  logic            CLK = 1'b0;
  logic            RST;
  logic [NR-1:0]   REQ_VALID;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]   REQ_READY;
  logic            FIFO_FULL;
  logic            FIFO_W_EN;
  logic [DW-1:0]   FIFO_DATA_IN;
  logic [1:0]      GRANT_ID;
  logic            BUSY;
  int total = 0;
  int bad = 0;
  int m_owner, m_left, m_last, m_gid;
  typedef struct {
    logic [3:0] v;
    logic       f;
    logic       busy;
    logic       wen;
    logic [3:0] rdy;
    logic [1:0] gid;
    logic [7:0] din;
  } vec_t;
  vec_t tv[18];
  localparam logic [31:0] FIXED_DATA = 32'h0D0C0B0A;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .REQ_IDX_W(2),
    .MAX_BURST(MB),
    .BURST_W(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ_VALID(REQ_VALID),
    .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY),
    .FIFO_FULL(FIFO_FULL),
    .FIFO_W_EN(FIFO_W_EN),
    .FIFO_DATA_IN(FIFO_DATA_IN),
    .GRANT_ID(GRANT_ID),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic f);
    REQ_VALID = v;
    REQ_DATA = d;
    FIFO_FULL = f;
    #2;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic f, input logic b, input logic w,
                              input logic [3:0] r, input logic [1:0] g, input logic [7:0] d);
    vec_t t;
    t.v = v; t.f = f; t.busy = b; t.wen = w; t.rdy = r; t.gid = g; t.din = d;
    return t;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left = 0;
    m_last = NR - 1;
    m_gid = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ_VALID = '1;
    REQ_DATA = FIXED_DATA;
    FIFO_FULL = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_wen", FIFO_W_EN, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_gid", GRANT_ID, 0);
    chk("rst_din", FIFO_DATA_IN, 0);
    RST = 1'b0;
    REQ_VALID = '0;
    model_reset();
  endtask

  // compare outputs to the transaction-level model for the current inputs, then advance the model one cycle
  task automatic model_cycle(input string tag);
    logic ok;
    int rdy, din;
    ok = m_owner >= 0 && REQ_VALID[m_owner] && !FIFO_FULL;
    rdy = ok ? (1 << m_owner) : 0;
    din = m_owner >= 0 ? int'(REQ_DATA[m_owner*DW +: DW]) : 0;
    chk({tag, "_busy"}, BUSY, m_owner >= 0 ? 1 : 0);
    chk({tag, "_wen"}, FIFO_W_EN, ok);
    chk({tag, "_ready"}, REQ_READY, rdy);
    chk({tag, "_din"}, FIFO_DATA_IN, din);
    chk({tag, "_gid"}, GRANT_ID, m_gid);
    if (m_owner < 0) begin
      for (int j = 1; j <= NR; j++) begin
        int k;
        k = (m_last + j) % NR;
        if (m_owner < 0 && REQ_VALID[k]) begin
          m_owner = k;
          m_gid = k;
          m_left = MB;
        end
      end
    end else if (!REQ_VALID[m_owner]) begin
      m_last = m_owner;
      m_owner = -1;
    end else if (ok) begin
      m_left--;
      if (m_left == 0) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    int grants[$];
    int pulses;
    logic prev_busy;
    int exp_seq[5];
    int prod[4][$];
    int q[$];
    int exp_q[$];
    int written;
    bit done;
    tv[0]  = mk(4'b0010, 0, 0, 0, 4'b0000, 0, 8'h00);
    tv[1]  = mk(4'b1010, 0, 1, 1, 4'b0010, 1, 8'h0B);
    tv[2]  = mk(4'b1000, 0, 1, 0, 4'b0000, 1, 8'h0B);
    tv[3]  = mk(4'b1000, 0, 0, 0, 4'b0000, 1, 8'h00);
    tv[4]  = mk(4'b1000, 0, 1, 1, 4'b1000, 3, 8'h0D);
    tv[5]  = mk(4'b0000, 0, 1, 0, 4'b0000, 3, 8'h0D);
    tv[6]  = mk(4'b0100, 0, 0, 0, 4'b0000, 3, 8'h00);
    tv[7]  = mk(4'b0100, 0, 1, 1, 4'b0100, 2, 8'h0C);
    tv[8]  = mk(4'b0100, 0, 1, 1, 4'b0100, 2, 8'h0C);
    for (int i = 9; i <= 13; i++) tv[i] = mk(4'b0100, 1, 1, 0, 4'b0000, 2, 8'h0C);
    tv[14] = mk(4'b0100, 0, 1, 1, 4'b0100, 2, 8'h0C);
    tv[15] = mk(4'b0100, 0, 1, 1, 4'b0100, 2, 8'h0C);
    tv[16] = mk(4'b0100, 0, 0, 0, 4'b0000, 2, 8'h00);
    tv[17] = mk(4'b0100, 0, 1, 1, 4'b0100, 2, 8'h0C);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply(tv[i].v, FIXED_DATA, tv[i].f);
      chk($sformatf("vec%0d_busy", i), BUSY, tv[i].busy);
      chk($sformatf("vec%0d_wen", i), FIFO_W_EN, tv[i].wen);
      chk($sformatf("vec%0d_ready", i), REQ_READY, tv[i].rdy);
      chk($sformatf("vec%0d_gid", i), GRANT_ID, tv[i].gid);
      chk($sformatf("vec%0d_din", i), FIFO_DATA_IN, tv[i].din);
      tick();
    end

    do_reset();
    pulses = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 25; c++) begin
      apply(4'b1111, FIXED_DATA, 1'b0);
      if (BUSY && !prev_busy) grants.push_back(int'(GRANT_ID));
      if (FIFO_W_EN) pulses++;
      prev_busy = BUSY;
      tick();
    end
    exp_seq = '{0, 1, 2, 3, 0};
    chk("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk($sformatf("rr_grant%0d", i), grants[i], exp_seq[i]);
    chk("rr_pulses", pulses, 20);

    do_reset();
    apply(4'b1111, FIXED_DATA, 1'b0);
    tick();
    apply(4'b1111, FIXED_DATA, 1'b0);
    tick();
    apply(4'b1111, FIXED_DATA, 1'b0);
    tick();
    apply(4'b1111, FIXED_DATA, 1'b0);
    chk("midrst_pre_wen", FIFO_W_EN, 1);
    RST = 1'b1;
    #1;
    chk("midrst_ready", REQ_READY, 0);
    chk("midrst_wen", FIFO_W_EN, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_gid", GRANT_ID, 0);
    tick();
    RST = 1'b0;
    apply(4'b1010, FIXED_DATA, 1'b0);
    chk("midrst_idle", BUSY, 0);
    tick();
    apply(4'b1010, FIXED_DATA, 1'b0);
    chk("midrst_regrant_busy", BUSY, 1);
    chk("midrst_regrant_gid", GRANT_ID, 1);

    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
      model_cycle("rand");
      tick();
    end

    do_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) prod[p].push_back(p * 16 + k);
    written = 0;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      logic [3:0] v;
      logic [31:0] d;
      v = '0;
      d = '0;
      for (int p = 0; p < 4; p++) begin
        if (prod[p].size() > 0) begin
          v[p] = 1'b1;
          d[p*DW +: DW] = 8'(prod[p][0]);
        end
      end
      apply(v, d, q.size() >= 8);
      if (m_owner >= 0 && REQ_VALID[m_owner] && !FIFO_FULL) exp_q.push_back(prod[m_owner][0]);
      if (FIFO_W_EN) begin
        q.push_back(int'(FIFO_DATA_IN));
        written++;
      end
      model_cycle("fifo");
      for (int p = 0; p < 4; p++)
        if (REQ_READY[p] && prod[p].size() > 0) void'(prod[p].pop_front());
      if (n % 3 == 0 && q.size() > 0) begin
        int e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : -1;
        chk("fifo_order", q.pop_front(), e);
      end
      done = q.size() == 0 && prod[0].size() == 0 && prod[1].size() == 0 &&
             prod[2].size() == 0 && prod[3].size() == 0;
      tick();
    end
    chk("fifo_drained", done, 1);
    chk("fifo_words", written, 32);
    chk("fifo_log_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
